// File: rtl/pulse_stat_pkg.sv
// Shared types and helpers for the windowed pulse statistics controller.
package pulse_stat_pkg;
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   localparam int unsigned DROP_W = 16;

   function automatic int unsigned ch_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/pulse_cnt.sv
// Wrapping pulse counter: synchronous clear wins over increment.
module pulse_cnt #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clc,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clc)      cnt_d = '0;
      else if (inc) cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pulse_stat_sched.sv
// Window timer, snapshot/clear scheduler and valid/ready stream of per-channel counts.
module pulse_stat_sched
   import pulse_stat_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned WIN_W     = 24
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en_i,
   input  logic [WIN_W-1:0]            win_len_i,
   input  logic                        snap_req_i,
   input  logic [NUM_CH-1:0]           pulse_i,
   output logic                        m_valid_o,
   input  logic                        m_ready_i,
   output logic [CNT_WIDTH-1:0]        m_data_o,
   output logic [ch_w(NUM_CH)-1:0]     m_ch_o,
   output logic                        m_last_o,
   output logic                        busy_o,
   output logic [DROP_W-1:0]           drop_cnt_o
);
   localparam int unsigned CH_W = ch_w(NUM_CH);

   logic [CNT_WIDTH-1:0] cnt_c    [NUM_CH];
   logic [CNT_WIDTH-1:0] snap_c   [NUM_CH];
   logic [CNT_WIDTH-1:0] shadow_q [NUM_CH];
   logic [CNT_WIDTH-1:0] shadow_d [NUM_CH];

   state_e               state_q, state_d;
   logic [WIN_W-1:0]     timer_q, timer_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] data_q, data_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic                 last_q, last_d;
   logic                 busy_q, busy_d;
   logic [DROP_W-1:0]    drop_q, drop_d;

   logic term_c, event_c, hs_c, final_hs_c, accept_c, drop_c, clr_c;
   logic [CH_W-1:0] ch_inc_c;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      pulse_cnt #(.WIDTH(CNT_WIDTH)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clc   (clr_c),
         .inc   (pulse_i[g]),
         .cnt_o (cnt_c[g])
      );
      // Pulse landing in the clear cycle is folded into the snapshot.
      assign snap_c[g] = cnt_c[g] + CNT_WIDTH'(pulse_i[g]);
   end

   always_comb begin
      term_c     = en_i && (win_len_i != '0) && (timer_q >= (win_len_i - WIN_W'(1)));
      event_c    = term_c || (snap_req_i && en_i);
      hs_c       = valid_q && m_ready_i;
      final_hs_c = hs_c && last_q;
      accept_c   = event_c && ((state_q == IDLE) || final_hs_c);
      drop_c     = event_c && !accept_c;
      clr_c      = event_c || !en_i;
      ch_inc_c   = ch_q + CH_W'(1);

      state_d  = state_q;
      valid_d  = valid_q;
      data_d   = data_q;
      ch_d     = ch_q;
      last_d   = last_q;
      busy_d   = busy_q;
      drop_d   = drop_q;
      shadow_d = shadow_q;

      if (!en_i || event_c)     timer_d = '0;
      else if (win_len_i != '0) timer_d = timer_q + WIN_W'(1);
      else                      timer_d = '0;

      if (drop_c && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

      case (state_q)
         IDLE: ;
         SEND: begin
            if (final_hs_c) begin
               state_d = IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               data_d  = '0;
               ch_d    = '0;
               last_d  = 1'b0;
            end else if (hs_c) begin
               ch_d   = ch_inc_c;
               data_d = shadow_q[ch_inc_c];
               last_d = (ch_inc_c == CH_W'(NUM_CH - 1));
            end
         end
         default: state_d = IDLE;
      endcase

      // Accepted snapshot (from IDLE or on the final handshake) restarts the stream at ch 0.
      if (accept_c) begin
         shadow_d = snap_c;
         state_d  = SEND;
         valid_d  = 1'b1;
         busy_d   = 1'b1;
         ch_d     = '0;
         data_d   = snap_c[0];
         last_d   = (NUM_CH == 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         ch_q     <= ch_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         drop_q   <= drop_d;
         shadow_q <= shadow_d;
      end
   end

   assign m_valid_o  = valid_q;
   assign m_data_o   = data_q;
   assign m_ch_o     = ch_q;
   assign m_last_o   = last_q;
   assign busy_o     = busy_q;
   assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_pulse_stat_sched.sv
// Randomized and directed bench for pulse_stat_sched against a queue-based reference model.
module tb_pulse_stat_sched;
   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned CNT_WIDTH = 32;
   localparam int unsigned WIN_W     = 24;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 en_i;
   logic [WIN_W-1:0]     win_len_i;
   logic                 snap_req_i;
   logic [NUM_CH-1:0]    pulse_i;
   logic                 m_valid_o;
   logic                 m_ready_i;
   logic [CNT_WIDTH-1:0] m_data_o;
   logic [1:0]           m_ch_o;
   logic                 m_last_o;
   logic                 busy_o;
   logic [15:0]          drop_cnt_o;

   pulse_stat_sched #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .WIN_W(WIN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .win_len_i  (win_len_i),
      .snap_req_i (snap_req_i),
      .pulse_i    (pulse_i),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_data_o   (m_data_o),
      .m_ch_o     (m_ch_o),
      .m_last_o   (m_last_o),
      .busy_o     (busy_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: live counts, window timer, and the queue of beats still to be sent.
   typedef struct {
      int          ch;
      logic [31:0] data;
   } beat_t;

   logic [31:0] m_cnt [NUM_CH];
   int          m_timer;
   int          m_drop;
   beat_t       m_q [$];

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
      m_timer = 0;
      m_drop  = 0;
      m_q.delete();
   endtask

   task automatic model_step(input bit en, input int win, input bit req,
                             input logic [NUM_CH-1:0] pls, input bit rdy);
      bit sending, hs, fin, term, ev;
      sending = (m_q.size() > 0);
      hs      = sending && rdy;
      fin     = hs && (m_q.size() == 1);
      term    = en && (win != 0) && (m_timer >= win - 1);
      ev      = term || (req && en);

      if (!en || ev)     m_timer = 0;
      else if (win != 0) m_timer = m_timer + 1;
      else               m_timer = 0;

      if (hs) void'(m_q.pop_front());
      if (ev) begin
         if (!sending || fin) begin
            for (int i = 0; i < NUM_CH; i++) begin
               beat_t b;
               b.ch   = i;
               b.data = m_cnt[i] + 32'(pls[i]);
               m_q.push_back(b);
            end
         end else if (m_drop < 65535) begin
            m_drop++;
         end
         for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
      end else if (!en) begin
         for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) m_cnt[i] = m_cnt[i] + 32'(pls[i]);
      end
   endtask

   task automatic compare_outputs();
      bit exp_v;
      exp_v = (m_q.size() > 0);
      check_eq("valid", 32'(m_valid_o), 32'(exp_v));
      check_eq("busy",  32'(busy_o),    32'(exp_v));
      check_eq("drop",  32'(drop_cnt_o), 32'(m_drop));
      if (exp_v && m_valid_o) begin
         check_eq("ch",   32'(m_ch_o),   32'(m_q[0].ch));
         check_eq("data", m_data_o,      m_q[0].data);
         check_eq("last", 32'(m_last_o), 32'(m_q[0].ch == NUM_CH - 1));
      end
   endtask

   task automatic step(input bit en, input int win, input bit req,
                       input logic [NUM_CH-1:0] pls, input bit rdy);
      @(negedge clk);
      en_i       = en;
      win_len_i  = WIN_W'(win);
      snap_req_i = req;
      pulse_i    = pls;
      m_ready_i  = rdy;
      model_step(en, win, req, pls, rdy);
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_valid"}, 32'(m_valid_o),  32'd0);
      check_eq({tag, "_data"},  m_data_o,        32'd0);
      check_eq({tag, "_ch"},    32'(m_ch_o),     32'd0);
      check_eq({tag, "_last"},  32'(m_last_o),   32'd0);
      check_eq({tag, "_busy"},  32'(busy_o),     32'd0);
      check_eq({tag, "_drop"},  32'(drop_cnt_o), 32'd0);
   endtask

   initial begin
      logic [NUM_CH-1:0] p;
      int win;
      bit en;

      rst_n = 1'b0; en_i = 1'b0; win_len_i = '0; snap_req_i = 1'b0;
      pulse_i = '0; m_ready_i = 1'b0;
      model_reset();
      #23;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Auto window of 10: 3 pulses on ch0, 7 on ch2.
      for (int c = 0; c < 10; c++) begin
         p = '0;
         if (c == 1 || c == 3 || c == 5) p[0] = 1'b1;
         if (c < 7) p[2] = 1'b1;
         step(1, 10, 0, p, 1);
      end
      check_eq("auto_first_valid", 32'(m_valid_o), 32'd1);
      check_eq("auto_ch0_data",    m_data_o,       32'd3);

      // Second window: ch1 pulses twice plus once on the terminal cycle.
      for (int c = 0; c < 10; c++) begin
         p = '0;
         if (c == 2 || c == 4 || c == 9) p[1] = 1'b1;
         step(1, 10, 0, p, 1);
      end
      // Third window carries no pulses; ch1 must report 0, not a leftover 1.
      for (int c = 0; c < 14; c++) step(1, 10, 0, '0, 1);

      // Backpressure: manual snapshot, accept ch0, then stall 20 cycles at ch1.
      for (int c = 0; c < 4; c++) step(1, 0, 0, 4'b1111, 1);
      step(1, 0, 1, 4'b0000, 1);
      step(1, 0, 0, 4'b0000, 1);
      for (int c = 0; c < 20; c++) step(1, 0, 0, 4'(c), 0);
      for (int c = 0; c < 6; c++) step(1, 0, 0, '0, 1);

      // Overrun: short window, sink stalled.
      for (int c = 0; c < 16; c++) step(1, 3, 0, 4'b0101, 0);
      for (int c = 0; c < 6; c++) step(1, 0, 0, '0, 1);

      // Seamless accept: window of 4 matches a 4-beat stream.
      for (int c = 0; c < 16; c++) step(1, 4, 0, 4'($urandom), 1);
      for (int c = 0; c < 6; c++) step(1, 0, 0, '0, 1);

      // Manual snapshot: 5 pulses on ch3, then reset mid-stream.
      for (int c = 0; c < 5; c++) step(1, 0, 0, 4'b1000, 1);
      step(1, 0, 1, 4'b0000, 0);
      step(1, 0, 0, 4'b0000, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) step(1, 0, 0, 4'b1111, 1);

      // Random traffic segments.
      for (int seg = 0; seg < 12; seg++) begin
         win = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 12));
         en  = 1'b1;
         for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 31) == 0) en = ~en;
            step(en, win, ($urandom_range(0, 15) == 0), 4'($urandom),
                 ($urandom_range(0, 9) < 7));
         end
      end
      for (int c = 0; c < 10; c++) step(0, 0, 0, '0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
